// File: rtl/simd_pkg.sv
// ============================================================================
// Module : simd_pkg
// Brief  : Shared defaults, lane type and FSM states for simd_accumulator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package simd_pkg;

  localparam int c_LANES = 2;
  localparam int c_DW    = 32;
  localparam int c_CW    = 8;

  typedef logic signed [c_DW-1:0] lane_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/simd_sat_add.sv
// ============================================================================
// Module : simd_sat_add
// Brief  : One-lane signed adder; clamps and flags overflow when
//          SIMD_ACC_SAT_EN is defined, otherwise wraps with ovf tied low.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module simd_sat_add import simd_pkg::*; #(
  parameter int DW = c_DW
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] sum,
  output logic          ovf
);

  logic [DW-1:0] w_raw;
  assign w_raw = a + b;

`ifdef SIMD_ACC_SAT_EN
  logic w_ovf;
  // Signed overflow: operands agree in sign but the result does not.
  assign w_ovf = (a[DW-1] == b[DW-1]) && (w_raw[DW-1] != a[DW-1]);
  assign ovf   = w_ovf;
  assign sum   = !w_ovf  ? w_raw :
                 a[DW-1] ? {1'b1, {(DW-1){1'b0}}} :
                           {1'b0, {(DW-1){1'b1}}};
`else
  assign ovf = 1'b0;
  assign sum = w_raw;
`endif

endmodule

`default_nettype wire

// File: rtl/simd_accumulator.sv
// ============================================================================
// Module : simd_accumulator
// Brief  : LANES-wide signed accumulator over LEN beats with a DONE
//          handshake. Saturation enabled by macro SIMD_ACC_SAT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module simd_accumulator import simd_pkg::*; #(
  parameter int LANES = c_LANES,
  parameter int DW    = c_DW,
  parameter int CW    = c_CW
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic [CW-1:0]       LEN,
  input  logic [LANES*DW-1:0] IN_DATA,
  input  logic                IN_VALID,
  output logic                IN_READY,
  output logic [LANES*DW-1:0] ACC_OUT,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic                BUSY,
  output logic [LANES-1:0]    OVF
);

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [LANES*DW-1:0] r_acc;
  logic [LANES-1:0]    r_ovf;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_busy;

  logic [LANES*DW-1:0] w_sum;
  logic [LANES-1:0]    w_ovf;
  logic                w_beat;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    simd_sat_add #(.DW(DW)) u_add (
      .a   (r_acc[i*DW +: DW]),
      .b   (IN_DATA[i*DW +: DW]),
      .sum (w_sum[i*DW +: DW]),
      .ovf (w_ovf[i])
    );
  end

  assign w_beat = IN_VALID && r_in_ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_ovf       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            r_acc  <= '0;
            r_ovf  <= '0;
            r_cnt  <= LEN;
            r_busy <= 1'b1;
            if (LEN == '0) begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state    <= ST_ACCUM;
              r_in_ready <= 1'b1;
            end
          end
        end
        ST_ACCUM: begin
          if (w_beat) begin
            r_acc <= w_sum;
            r_ovf <= r_ovf | w_ovf;
            r_cnt <= r_cnt - CW'(1);
            // The count==1 beat is the last one included in the result.
            if (r_cnt == CW'(1)) begin
              r_state     <= ST_DONE;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (OUT_READY) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign IN_READY  = r_in_ready;
  assign OUT_VALID = r_out_valid;
  assign BUSY      = r_busy;
  assign ACC_OUT   = r_acc;
  assign OVF       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_simd_accumulator.sv
// ============================================================================
// Module : tb_simd_accumulator
// Brief  : Directed scoreboard bench for simd_accumulator (2 lanes x 32 bit).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_simd_accumulator;

  localparam int LANES = 2;
  localparam int DW    = 32;
  localparam int CW    = 8;

  logic                CLK = 1'b0;
  logic                RST;
  logic                START;
  logic [CW-1:0]       LEN;
  logic [LANES*DW-1:0] IN_DATA;
  logic                IN_VALID;
  logic                IN_READY;
  logic [LANES*DW-1:0] ACC_OUT;
  logic                OUT_VALID;
  logic                OUT_READY;
  logic                BUSY;
  logic [LANES-1:0]    OVF;

  simd_accumulator #(.LANES(LANES), .DW(DW), .CW(CW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .LEN       (LEN),
    .IN_DATA   (IN_DATA),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .ACC_OUT   (ACC_OUT),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .BUSY      (BUSY),
    .OVF       (OVF)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [63:0] acc;
    logic [1:0]  ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void push(input logic [31:0] l0, input logic [31:0] l1, input logic [1:0] ov);
    exp_t e;
    e.acc = {l1, l0};
    e.ovf = ov;
    sb.push_back(e);
  endfunction

  // Monitor: every accepted result is matched against the oldest expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (OUT_VALID && OUT_READY) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h expected none", ACC_OUT);
      end else begin
        e = sb.pop_front();
        chk("result_acc", ACC_OUT, e.acc);
        chk("result_ovf", 64'(OVF), 64'(e.ovf));
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic start(input logic [CW-1:0] len);
    START = 1'b1;
    LEN   = len;
    cyc();
    START = 1'b0;
  endtask

  task automatic beat(input logic [31:0] l0, input logic [31:0] l1);
    int n;
    IN_DATA  = {l1, l0};
    IN_VALID = 1'b1;
    n = 0;
    forever begin
      @(negedge CLK);
      if (IN_READY) break;
      n++;
      if (n > 20) begin
        checks++;
        errors++;
        $display("FAIL beat_timeout: got IN_READY=0 expected 1");
        break;
      end
    end
    cyc();
    IN_VALID = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; START = 1'b0; LEN = '0; IN_VALID = 1'b0; IN_DATA = '0; OUT_READY = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_in_ready",  64'(IN_READY),  64'd0);
    chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
    chk("rst_busy",      64'(BUSY),      64'd0);
    chk("rst_acc",       ACC_OUT,        64'd0);
    chk("rst_ovf",       64'(OVF),       64'd0);
    cyc();
    RST = 1'b0;

    // Three back-to-back beats.
    cyc();
    push(32'd9, 32'd12, 2'b00);
    start(8'd3);
    beat(32'd1, 32'd2);
    beat(32'd3, 32'd4);
    beat(32'd5, 32'd6);
    @(negedge CLK);
    chk("latency_out_valid", 64'(OUT_VALID), 64'd1);
    cyc();
    @(negedge CLK);
    chk("back_to_idle", 64'(BUSY), 64'd0);

    // Gapped beats with IN_READY held.
    cyc();
    push(32'd7, 32'hFFFF_FFF9, 2'b00);
    start(8'd2);
    beat(32'd10, 32'hFFFF_FFF6);
    repeat (4) begin
      @(negedge CLK);
      chk("gap_in_ready", 64'(IN_READY), 64'd1);
      cyc();
    end
    beat(32'hFFFF_FFFD, 32'd3);
    cyc(); cyc();

    // Overflow on lane 0.
`ifdef SIMD_ACC_SAT_EN
    push(32'h7FFF_FFFF, 32'd0, 2'b01);
`else
    push(32'h8000_0010, 32'd0, 2'b00);
`endif
    start(8'd2);
    beat(32'h7FFF_FFF0, 32'd0);
    beat(32'h0000_0020, 32'd0);
    cyc(); cyc();

    // LEN=0 with consumer stalled.
    OUT_READY = 1'b0;
    push(32'd0, 32'd0, 2'b00);
    start(8'd0);
    repeat (5) begin
      @(negedge CLK);
      chk("stall_out_valid", 64'(OUT_VALID), 64'd1);
      chk("stall_acc",       ACC_OUT,        64'd0);
      chk("stall_busy",      64'(BUSY),      64'd1);
      cyc();
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    cyc();
    @(negedge CLK);
    chk("len0_idle", 64'(BUSY), 64'd0);
    cyc();

    // Reset mid-accumulation, then a fresh single-beat run.
    start(8'd4);
    beat(32'd5, 32'd5);
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    @(negedge CLK);
    chk("midrst_busy",      64'(BUSY),      64'd0);
    chk("midrst_acc",       ACC_OUT,        64'd0);
    chk("midrst_in_ready",  64'(IN_READY),  64'd0);
    chk("midrst_out_valid", 64'(OUT_VALID), 64'd0);
    cyc();
    push(32'd2, 32'd2, 2'b00);
    start(8'd1);
    beat(32'd2, 32'd2);
    cyc(); cyc();

    // START ignored in ACCUM and alongside OUT_READY in DONE.
    OUT_READY = 1'b0;
    push(32'd3, 32'd4, 2'b00);
    start(8'd2);
    beat(32'd1, 32'd1);
    START = 1'b1;
    LEN   = 8'd1;
    cyc();
    START = 1'b0;
    @(negedge CLK);
    chk("accum_start_in_ready", 64'(IN_READY),  64'd1);
    chk("accum_start_no_done",  64'(OUT_VALID), 64'd0);
    cyc();
    beat(32'd2, 32'd3);
    @(negedge CLK);
    chk("ign_done_valid", 64'(OUT_VALID), 64'd1);
    cyc();
    START     = 1'b1;
    LEN       = 8'd5;
    OUT_READY = 1'b1;
    cyc();
    START = 1'b0;
    @(negedge CLK);
    chk("done_start_busy",      64'(BUSY),      64'd0);
    chk("done_start_out_valid", 64'(OUT_VALID), 64'd0);
    cyc();
    @(negedge CLK);
    chk("done_start_still_idle", 64'(BUSY), 64'd0);

    cyc();
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
